// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V core constants: NOP encoding, default widths, fetch FSM states
package riscv_pkg;

    localparam int INST_WIDTH_DEF = 32;
    localparam int PC_WIDTH_DEF   = 32;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    localparam logic [1:0] FS_IDLE = 2'd0;
    localparam logic [1:0] FS_WAIT = 2'd1;
    localparam logic [1:0] FS_HOLD = 2'd2;
    localparam logic [1:0] FS_DROP = 2'd3;

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction-memory request/response bundle used by the fetch stage
interface fetch_stage_if import riscv_pkg::*; #(
    parameter int PC_WIDTH   = PC_WIDTH_DEF,
    parameter int INST_WIDTH = INST_WIDTH_DEF
);
    logic                  imem_req;
    logic [PC_WIDTH-1:0]   imem_addr;
    logic                  imem_rvalid;
    logic [INST_WIDTH-1:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_rvalid, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_rvalid, output imem_rdata);
endinterface

// File: rtl/fetch_buf.sv
// rtl/fetch_buf.sv - one-entry holding buffer for a response that arrived while fetch was stalled
module fetch_buf import riscv_pkg::*; #(
    parameter int WIDTH = INST_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);
    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= WIDTH'(NOP_INST);
        end else if (load_i) begin
            data_q <= data_i;
        end
    end

    assign data_o = data_q;
endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage: PC register, single-outstanding imem fetch, stall hold and redirect flush
module fetch_stage import riscv_pkg::*; #(
    parameter int                  INST_WIDTH = INST_WIDTH_DEF,
    parameter int                  PC_WIDTH   = PC_WIDTH_DEF,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  Stall_F,
    input  logic                  PCSrc_E,
    input  logic [PC_WIDTH-1:0]   PCTarget_E,
    fetch_stage_if.master         imem,
    output logic [INST_WIDTH-1:0] inst_F,
    output logic [PC_WIDTH-1:0]   PC_F,
    output logic [PC_WIDTH-1:0]   PCplus4_F
);
    localparam logic [INST_WIDTH-1:0] NOP = INST_WIDTH'(NOP_INST);

    logic [1:0]            state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d, pc_plus4;
    logic                  req_c;
    logic [PC_WIDTH-1:0]   addr_c;
    logic [INST_WIDTH-1:0] inst_c;
    logic                  buf_load;
    logic [INST_WIDTH-1:0] buf_data;

    assign pc_plus4 = pc_q + PC_WIDTH'(4);

    fetch_buf #(.WIDTH(INST_WIDTH)) u_buf (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (buf_load),
        .data_i (imem.imem_rdata),
        .data_o (buf_data)
    );

    // A redirect always wins; a response in hand lets the next request go out the same cycle.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_c    = 1'b0;
        addr_c   = pc_q;
        inst_c   = NOP;
        buf_load = 1'b0;
        case (state_q)
            FS_IDLE: begin
                req_c   = 1'b1;
                state_d = FS_WAIT;
            end
            FS_WAIT: begin
                if (PCSrc_E) begin
                    pc_d = PCTarget_E;
                    if (imem.imem_rvalid) begin
                        req_c  = 1'b1;
                        addr_c = PCTarget_E;
                    end else begin
                        state_d = FS_DROP;
                    end
                end else if (imem.imem_rvalid) begin
                    inst_c = imem.imem_rdata;
                    if (Stall_F) begin
                        buf_load = 1'b1;
                        state_d  = FS_HOLD;
                    end else begin
                        pc_d   = pc_plus4;
                        req_c  = 1'b1;
                        addr_c = pc_plus4;
                    end
                end
            end
            FS_HOLD: begin
                inst_c = buf_data;
                if (PCSrc_E) begin
                    pc_d    = PCTarget_E;
                    req_c   = 1'b1;
                    addr_c  = PCTarget_E;
                    state_d = FS_WAIT;
                end else if (!Stall_F) begin
                    pc_d    = pc_plus4;
                    req_c   = 1'b1;
                    addr_c  = pc_plus4;
                    state_d = FS_WAIT;
                end
            end
            default: begin
                // Stale response still in flight; track the newest target until it lands.
                if (PCSrc_E) begin
                    pc_d = PCTarget_E;
                end
                if (imem.imem_rvalid) begin
                    req_c   = 1'b1;
                    addr_c  = pc_d;
                    state_d = FS_WAIT;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FS_IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign imem.imem_req  = req_c & rst_n;
    assign imem.imem_addr = addr_c;
    assign inst_F         = inst_c;
    assign PC_F           = pc_q;
    assign PCplus4_F      = pc_plus4;
endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage with latency-programmable imem model
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Stall_F;
    logic        PCSrc_E;
    logic [31:0] PCTarget_E;
    logic [31:0] inst_F;
    logic [31:0] PC_F;
    logic [31:0] PCplus4_F;

    fetch_stage_if #(.PC_WIDTH(32), .INST_WIDTH(32)) imem ();

    fetch_stage #(.INST_WIDTH(32), .PC_WIDTH(32), .RESET_PC(32'h0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Stall_F    (Stall_F),
        .PCSrc_E    (PCSrc_E),
        .PCTarget_E (PCTarget_E),
        .imem       (imem),
        .inst_F     (inst_F),
        .PC_F       (PC_F),
        .PCplus4_F  (PCplus4_F)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          mem_lat;
    bit          mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;
    logic        req_seen;
    logic [31:0] req_addr;
    logic [31:0] exp_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {8'hC5, a[23:0]};
    endfunction

    // Drive the memory response just after the active edge.
    task automatic cycle();
        @(posedge clk);
        #1;
        if (mem_busy && mem_cnt == 1) begin
            imem.imem_rvalid = 1'b1;
            imem.imem_rdata  = mem_word(mem_addr);
            mem_busy         = 1'b0;
        end else begin
            imem.imem_rvalid = 1'b0;
            imem.imem_rdata  = 32'hDEAD_BEEF;
            if (mem_busy) mem_cnt--;
        end
    endtask

    // Observe outputs on the falling edge: capture requests, score delivered instructions.
    task automatic sample();
        logic [31:0] exp;
        @(negedge clk);
        req_seen = imem.imem_req;
        req_addr = imem.imem_addr;
        if (rst_n && imem.imem_req) begin
            checks++;
            if (mem_busy) begin
                errors++;
                $display("FAIL outstanding: req addr %h while %h still pending", imem.imem_addr, mem_addr);
            end
            mem_busy = 1'b1;
            mem_addr = imem.imem_addr;
            mem_cnt  = mem_lat;
        end
        if (rst_n && inst_F !== NOP && !Stall_F && !PCSrc_E) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_extra: got PC %h inst %h, expected nothing", PC_F, inst_F);
            end else begin
                exp = exp_q.pop_front();
                if (PC_F !== exp || inst_F !== mem_word(exp)) begin
                    errors++;
                    $display("FAIL sb_deliver: got PC %h inst %h, expected PC %h inst %h",
                             PC_F, inst_F, exp, mem_word(exp));
                end
            end
        end
    endtask

    task automatic do_reset(input int lat);
        mem_lat    = lat;
        Stall_F    = 1'b0;
        PCSrc_E    = 1'b0;
        PCTarget_E = 32'h0;
        @(posedge clk);
        #1;
        rst_n            = 1'b0;
        mem_busy         = 1'b0;
        imem.imem_rvalid = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sample();
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (imem.imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", imem.imem_req); end
        checks++;
        if (inst_F !== NOP) begin errors++; $display("FAIL rst_inst: got %h expected %h", inst_F, NOP); end
        checks++;
        if (PC_F !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h expected 0", PC_F); end
        checks++;
        if (PCplus4_F !== 32'h4) begin errors++; $display("FAIL rst_pc4: got %h expected 4", PCplus4_F); end
    endtask

    task automatic test_one_cycle_mem();
        do_reset(1);
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(4 * i));
        checks++;
        if (req_seen !== 1'b1 || req_addr !== 32'h0) begin
            errors++; $display("FAIL idle_req: got req %b addr %h expected 1 / 0", req_seen, req_addr);
        end
        for (int k = 0; k < 8; k++) begin
            cycle();
            sample();
            checks++;
            if (req_seen !== 1'b1 || req_addr !== 32'(4 * (k + 1))) begin
                errors++; $display("FAIL b2b_req: got req %b addr %h expected 1 / %h", req_seen, req_addr, 32'(4 * (k + 1)));
            end
            checks++;
            if (inst_F === NOP) begin errors++; $display("FAIL b2b_bubble: got NOP expected instruction"); end
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_left: got %0d pending expected 0", exp_q.size()); end
    endtask

    task automatic test_latency3();
        do_reset(3);
        for (int i = 0; i < 3; i++) exp_q.push_back(32'(4 * i));
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                cycle();
                sample();
                checks++;
                if (j < 2) begin
                    if (inst_F !== NOP || req_seen !== 1'b0 || PC_F !== 32'(4 * i)) begin
                        errors++; $display("FAIL lat3_bubble: got inst %h req %b PC %h expected NOP / 0 / %h",
                                           inst_F, req_seen, PC_F, 32'(4 * i));
                    end
                end else if (req_seen !== 1'b1 || req_addr !== 32'(4 * (i + 1))) begin
                    errors++; $display("FAIL lat3_req: got req %b addr %h expected 1 / %h", req_seen, req_addr, 32'(4 * (i + 1)));
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL lat3_left: got %0d pending expected 0", exp_q.size()); end
    endtask

    task automatic test_stall();
        do_reset(1);
        for (int i = 0; i < 6; i++) exp_q.push_back(32'(4 * i));
        for (int k = 0; k < 4; k++) begin
            cycle();
            sample();
        end
        for (int s = 0; s < 4; s++) begin
            cycle();
            Stall_F = 1'b1;
            sample();
            checks++;
            if (inst_F !== mem_word(32'h10) || PC_F !== 32'h10 || req_seen !== 1'b0) begin
                errors++; $display("FAIL stall_hold: got inst %h PC %h req %b expected %h / 10 / 0",
                                   inst_F, PC_F, req_seen, mem_word(32'h10));
            end
        end
        cycle();
        Stall_F = 1'b0;
        sample();
        checks++;
        if (req_seen !== 1'b1 || req_addr !== 32'h14) begin
            errors++; $display("FAIL stall_release: got req %b addr %h expected 1 / 14", req_seen, req_addr);
        end
        cycle();
        sample();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL stall_left: got %0d pending expected 0", exp_q.size()); end
    endtask

    task automatic test_redirect_wait();
        do_reset(3);
        exp_q.push_back(32'h100);
        cycle();
        PCSrc_E    = 1'b1;
        PCTarget_E = 32'h100;
        sample();
        checks++;
        if (inst_F !== NOP || req_seen !== 1'b0) begin
            errors++; $display("FAIL redir_wait: got inst %h req %b expected NOP / 0", inst_F, req_seen);
        end
        cycle();
        PCSrc_E = 1'b0;
        sample();
        cycle();
        sample();
        checks++;
        if (inst_F !== NOP || req_seen !== 1'b1 || req_addr !== 32'h100) begin
            errors++; $display("FAIL redir_drop: got inst %h req %b addr %h expected NOP / 1 / 100",
                               inst_F, req_seen, req_addr);
        end
        for (int n = 0; n < 8 && exp_q.size() != 0; n++) begin
            cycle();
            sample();
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL redir_timeout: got %0d pending expected 0", exp_q.size()); end
    endtask

    task automatic test_redirect_stall();
        do_reset(1);
        exp_q.push_back(32'h200);
        cycle();
        PCSrc_E    = 1'b1;
        Stall_F    = 1'b1;
        PCTarget_E = 32'h200;
        sample();
        checks++;
        if (inst_F !== NOP || req_seen !== 1'b1 || req_addr !== 32'h200) begin
            errors++; $display("FAIL redir_stall: got inst %h req %b addr %h expected NOP / 1 / 200",
                               inst_F, req_seen, req_addr);
        end
        cycle();
        PCSrc_E = 1'b0;
        Stall_F = 1'b0;
        sample();
        checks++;
        if (inst_F !== mem_word(32'h200) || req_seen !== 1'b1 || req_addr !== 32'h204) begin
            errors++; $display("FAIL redir_nohold: got inst %h req %b addr %h expected %h / 1 / 204",
                               inst_F, req_seen, req_addr, mem_word(32'h200));
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL redir_stall_left: got %0d pending expected 0", exp_q.size()); end
    endtask

    task automatic test_wrap();
        do_reset(1);
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0);
        cycle();
        PCSrc_E    = 1'b1;
        PCTarget_E = 32'hFFFF_FFFC;
        sample();
        cycle();
        PCSrc_E = 1'b0;
        sample();
        checks++;
        if (PCplus4_F !== 32'h0 || req_seen !== 1'b1 || req_addr !== 32'h0) begin
            errors++; $display("FAIL wrap: got pc4 %h req %b addr %h expected 0 / 1 / 0", PCplus4_F, req_seen, req_addr);
        end
        cycle();
        sample();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_left: got %0d pending expected 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        do_reset(3);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        for (int k = 0; k < 4; k++) begin
            cycle();
            sample();
        end
        @(posedge clk);
        #1;
        rst_n            = 1'b0;
        mem_busy         = 1'b0;
        imem.imem_rvalid = 1'b0;
        #1;
        checks++;
        if (imem.imem_req !== 1'b0 || inst_F !== NOP || PC_F !== 32'h0 || PCplus4_F !== 32'h4) begin
            errors++; $display("FAIL mid_reset: got req %b inst %h PC %h pc4 %h expected 0 / NOP / 0 / 4",
                               imem.imem_req, inst_F, PC_F, PCplus4_F);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sample();
        checks++;
        if (req_seen !== 1'b1 || req_addr !== 32'h0) begin
            errors++; $display("FAIL mid_refetch: got req %b addr %h expected 1 / 0", req_seen, req_addr);
        end
        for (int n = 0; n < 8 && exp_q.size() != 0; n++) begin
            cycle();
            sample();
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL mid_timeout: got %0d pending expected 0", exp_q.size()); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n            = 1'b0;
        Stall_F          = 1'b0;
        PCSrc_E          = 1'b0;
        PCTarget_E       = 32'h0;
        imem.imem_rvalid = 1'b0;
        imem.imem_rdata  = 32'h0;
        mem_busy         = 1'b0;
        mem_lat          = 1;
        mem_cnt          = 0;
        mem_addr         = 32'h0;
        test_reset();
        test_one_cycle_mem();
        test_latency3();
        test_stall();
        test_redirect_wait();
        test_redirect_stall();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter INST_WIDTH, default 32, instruction width.
REQ-002 SHALL have parameter PC_WIDTH, default 32, program-counter width.
REQ-003 SHALL have parameter RESET_PC, default 0, first fetch address.
REQ-004 SHALL have port clk  in  1  rising-edge clock.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port Stall_F  in  1  hazard-unit hold of fetch.
REQ-007 SHALL have port PCSrc_E  in  1  taken branch/jump redirect from EX.
REQ-008 SHALL have port PCTarget_E  in  PC_WIDTH  redirect address.
REQ-009 SHALL have port imem_req  out  1  one-cycle request pulse to instruction memory.
REQ-010 SHALL have port imem_addr  out  PC_WIDTH  request address, valid while imem_req=1.
REQ-011 SHALL have port imem_rvalid  in  1  response strobe, exactly one per request, at least 1 cycle after it.
REQ-012 SHALL have port imem_rdata  in  INST_WIDTH  response instruction, valid with imem_rvalid.
REQ-013 SHALL have ports inst_F  out  INST_WIDTH, PC_F  out  PC_WIDTH and PCplus4_F  out  PC_WIDTH, all feeding the IF/ID register.

Function
REQ-014 SHALL hold PC register pc_q; PC_F=pc_q and PCplus4_F=pc_q+4, with wrap-around modulo 2^PC_WIDTH.
REQ-015 SHALL keep at most one memory request outstanding.
REQ-016 SHALL implement states IDLE, WAIT (request outstanding for pc_q), HOLD (response buffered) and DROP (stale response pending).
REQ-017 IDLE: imem_req=1, imem_addr=pc_q, next state WAIT; inst_F=NOP (32'h00000013).
REQ-018 WAIT with no rvalid: inst_F=NOP, no request, pc_q held; if PCSrc_E, pc_q<=PCTarget_E and next state DROP.
REQ-019 WAIT, rvalid, !PCSrc_E, !Stall_F: inst_F=imem_rdata, pc_q<=pc_q+4, same-cycle imem_req with imem_addr=pc_q+4, stay WAIT (zero bubble at 1-cycle memory latency).
REQ-020 WAIT, rvalid, !PCSrc_E, Stall_F: inst_F=imem_rdata, data captured into one-entry buffer, next state HOLD.
REQ-021 WAIT, rvalid, PCSrc_E: response discarded, inst_F=NOP, pc_q<=PCTarget_E, same-cycle imem_req with imem_addr=PCTarget_E, stay WAIT.
REQ-022 HOLD: inst_F=buffer, no request; PCSrc_E -> pc_q<=PCTarget_E, request PCTarget_E, WAIT; else !Stall_F -> pc_q<=pc_q+4, request pc_q+4, WAIT; else stay HOLD.
REQ-023 DROP: inst_F=NOP; PCSrc_E updates pc_q to the new PCTarget_E; on rvalid the response is discarded and a same-cycle request issued for the (updated) target, next state WAIT.
REQ-024 PCSrc_E SHALL take priority over Stall_F in every state.
REQ-025 Stall_F SHALL never drop or duplicate a fetched instruction.

Reset
REQ-026 On rst_n=0: state IDLE, pc_q=RESET_PC, buffer=NOP, imem_req=0, inst_F=NOP, PC_F=RESET_PC, PCplus4_F=RESET_PC+4.
REQ-027 Reset asserted mid-request SHALL abandon the request; the first post-reset fetch SHALL be RESET_PC; the environment resets imem together with this block.

Structure
REQ-028 NOP encoding, INST_WIDTH/PC_WIDTH defaults and state enumeration SHALL live in shared package riscv_pkg.
REQ-029 The one-entry holding buffer SHALL be sub-module fetch_buf (load, data in, data out, async reset to NOP).

Verification
REQ-030 Reset release with 1-cycle memory: req addresses 0x0,0x4,0x8 on consecutive cycles; inst_F matches rdata each cycle, no NOPs after the first response.
REQ-031 3-cycle memory latency: two NOP cycles between instructions; pc_q advances only on rvalid.
REQ-032 Stall_F=1 for 4 cycles coincident with rvalid for PC 0x10: inst_F held at that instruction, no req issued; after release the next request is 0x14.
REQ-033 PCSrc_E with PCTarget_E=0x100 while WAIT without rvalid: late response for the old PC discarded (inst_F=NOP), next req addr=0x100, delivered PC_F=0x100.
REQ-034 PCSrc_E coincident with rvalid and Stall_F=1: response discarded, req addr=PCTarget_E same cycle, HOLD not entered.
REQ-035 rst_n pulsed low during WAIT: outputs return to reset values immediately; next req addr=RESET_PC.
